c880_bist_driver: RTL and testbench
===================================

# c880_bist_driver

Built-in self-test driver for the c880 8-bit ALU benchmark netlist: the sequential block on the far side of its 60 primary inputs and 26 primary outputs. On `start` it applies `N_PAT` pseudo-random 60-bit vectors from an LFSR, one per clock. It compacts each 26-bit response into a MISR and presents the final signature with a one-cycle `done` pulse. The signature is compared against a golden value in the test harness or the layout-verification flow.

## Interface
- `N_PAT`, 1024, number of vectors applied per run; legal range 1..65535.
- `LFSR_SEED`, 60'h1, initial LFSR state; must be nonzero (elaboration assertion).
- `MISR_SEED`, 26'h0, initial MISR state.
- `clk` in 1, single clock; everything is rising-edge.
- `rst_n` in 1, synchronous, active-low reset.
- `start` in 1, request a run; sampled only in IDLE.
- `busy` out 1, high in RUN.
- `done` out 1, one-cycle pulse when the signature becomes final.
- `pi` out 60, vector driven to DUT inputs; bit 0 feeds the lowest-numbered DUT input.
- `po` in 26, DUT outputs; combinational function of `pi`.
- `signature` out 26, MISR state.
- `sig_valid` out 1, signature final; held until next `start` or reset.
- `pat_cnt` out 16, vectors absorbed so far in the current run.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start` = 1 loads LFSR with `LFSR_SEED`, MISR with `MISR_SEED`, clears `pat_cnt` and `sig_valid`, and moves to RUN.
  - Otherwise all registers hold.
- RUN, every cycle:
  - MISR absorbs `po`.
  - LFSR steps and `pat_cnt` increments.
  - On the cycle where `pat_cnt` = `N_PAT`-1 (the last absorb), the next state is DONE.
- DONE, one cycle: `done` = 1, `sig_valid` = 1, LFSR and MISR hold, next state is IDLE.
- LFSR step (Fibonacci, x^60+x^59+1): next = {q[58:0], q[59]^q[58]}.
- `pi` always equals the LFSR register.
- MISR step (x^26+x^6+x^2+x+1): next = ({m[24:0],1'b0} ^ (m[25] ? 26'h47 : 0)) ^ `po`.
- `start` while `busy` or in DONE: ignored; no restart, no error.
- Reset mid-run: abort to IDLE, all outputs take their reset values, no `done` pulse.
- `pat_cnt` never wraps; it saturates at `N_PAT` and holds through IDLE.

## Timing
- Reset values:
  - state = IDLE.
  - `pi` = `LFSR_SEED`.
  - `signature` = `MISR_SEED`.
  - `pat_cnt` = 0.
  - `busy`, `done`, `sig_valid` = 0.
- `start` sampled at edge E0. RUN begins in cycle 1 with `pi` = `LFSR_SEED` and `busy` = 1.
- Cycle k of RUN presents vector k-1. The response is absorbed at the end of that cycle, so the DUT gets one full clock of combinational settling.
- `done` is high in cycle `N_PAT`+1. `busy` drops in that same cycle.
- Start-to-done latency is `N_PAT`+1 cycles. The earliest accepted restart is `start` sampled in cycle `N_PAT`+2.
- `N_PAT` = 1: one RUN cycle, `done` in cycle 2.

## Structure
- Shared package `bist_pkg`:
  - `PI_W` = 60 and `PO_W` = 26.
  - LFSR tap constant and `MISR_POLY` = 26'h47.
  - State enum `bist_state_t` (IDLE, RUN, DONE).
- One sub-module, `bist_misr`: parameterised width and polynomial, with `load`, `seed`, `en` and `d` inputs. It is reusable for other benchmark drivers.
- The LFSR, counter and FSM stay in the top.

## Test plan
- `N_PAT`=2, `MISR_SEED`=0, `po` tied to 26'h1, pulse `start` -> `done` in cycle 3, `signature` = 26'h3, `pat_cnt` = 2, `sig_valid` high afterwards.
- `LFSR_SEED`=1, `N_PAT`=64, monitor `pi` -> 60'h1, 60'h2, ... 60'h400000000000000 (bit 58) at RUN cycle 59, then 60'h800000000000001 at cycle 60.
- `N_PAT`=1, `po` = 26'h2000000, `MISR_SEED`=0 -> `signature` = 26'h2000000, `done` in cycle 2 exactly once.
- `start` held high for the whole run with `N_PAT`=8 -> single `done` at cycle 9, then a new run starts from the `start` sampled in cycle 10, with `sig_valid` cleared.
- `rst_n` low for one cycle at RUN cycle 5 -> IDLE next cycle, `pi` = `LFSR_SEED`, `signature` = `MISR_SEED`, no `done` pulse.
- Full `N_PAT`=1024 run against a behavioural model of the ALU netlist -> `signature` matches the reference-model MISR value; a single injected stuck-at on `po[0]` yields a different signature.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared constants, state encoding and LFSR step for the benchmark BIST drivers.
package bist_pkg;

  localparam int PI_W = 60;
  localparam int PO_W = 26;

  // Fibonacci taps for x^60 + x^59 + 1 (register bits 59 and 58)
  localparam logic [PI_W-1:0] LFSR_TAPS = 60'hC00000000000000;
  localparam logic [PO_W-1:0] MISR_POLY = 26'h47;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_t;

  function automatic logic [PI_W-1:0] lfsr_next(input logic [PI_W-1:0] q);
    return {q[PI_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift, conditional polynomial fold, then XOR in the response.
module bist_misr #(
  parameter int           W    = 26,
  parameter logic [W-1:0] POLY = 26'h47
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_next;

  always_comb begin
    q_next = {q[W-2:0], 1'b0} ^ (q[W-1] ? POLY : '0) ^ d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= seed;
    end else if (load) begin
      q <= seed;
    end else if (en) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/c880_bist_driver.sv
// BIST driver for the c880 ALU netlist: LFSR vectors out, MISR compaction of responses in.
//   state | meaning
//   IDLE  | waiting for start; all registers hold
//   RUN   | one vector applied and one response absorbed per cycle
//   DONE  | one cycle: done pulse, signature final
module c880_bist_driver
  import bist_pkg::*;
#(
  parameter int               N_PAT     = 1024,
  parameter logic [PI_W-1:0]  LFSR_SEED = 60'h1,
  parameter logic [PO_W-1:0]  MISR_SEED = 26'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [PI_W-1:0] pi,
  input  logic [PO_W-1:0] po,
  output logic [PO_W-1:0] signature,
  output logic            sig_valid,
  output logic [15:0]     pat_cnt
);

  if (LFSR_SEED == '0) begin : g_seed_chk
    $error("c880_bist_driver: LFSR_SEED must be nonzero");
  end
  if (N_PAT < 1 || N_PAT > 65535) begin : g_npat_chk
    $error("c880_bist_driver: N_PAT must be in 1..65535");
  end

  localparam logic [15:0] CNT_LAST = 16'(N_PAT - 1);
  localparam logic [15:0] CNT_MAX  = 16'(N_PAT);

  bist_state_t state, state_next;
  logic [PI_W-1:0] lfsr;
  logic start_run;
  logic running;
  logic last_pat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (pat_cnt == CNT_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN);
    done      = (state == DONE);
    start_run = (state == IDLE) && start;
    running   = (state == RUN);
    last_pat  = running && (pat_cnt == CNT_LAST);
  end

  // sig_valid rises with the last absorb so it is already high in the DONE cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr      <= LFSR_SEED;
      pat_cnt   <= '0;
      sig_valid <= 1'b0;
    end else if (start_run) begin
      lfsr      <= LFSR_SEED;
      pat_cnt   <= '0;
      sig_valid <= 1'b0;
    end else if (running) begin
      lfsr <= lfsr_next(lfsr);
      if (pat_cnt != CNT_MAX) pat_cnt <= pat_cnt + 16'd1;
      if (last_pat) sig_valid <= 1'b1;
    end
  end

  assign pi = lfsr;

  bist_misr #(
    .W    (PO_W),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_run),
    .seed  (MISR_SEED),
    .en    (running),
    .d     (po),
    .q     (signature)
  );

endmodule

// File: tb/tb_c880_bist_driver.sv
// Directed bench for c880_bist_driver: several parameterisations sharing one clock and reset.
module tb_c880_bist_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // behavioural stand-in for the c880 ALU netlist
  function automatic logic [25:0] alu(input logic [59:0] p);
    logic [7:0] a, b, res;
    logic [8:0] sum;
    a   = p[7:0];
    b   = p[15:8];
    sum = {1'b0, a} + {1'b0, b} + {8'd0, p[18]};
    case (p[17:16])
      2'd0:    res = sum[7:0];
      2'd1:    res = a & b;
      2'd2:    res = a | b;
      default: res = a ^ b;
    endcase
    return {p[59:53] ^ p[26:20], p[52:45] & p[44:37], ^p[36:19], (res == 8'd0), sum[8], res};
  endfunction

  function automatic logic [59:0] ref_lfsr(input logic [59:0] q);
    logic fb;
    fb = q[59] ^ q[58];
    return (q << 1) | {59'd0, fb};
  endfunction

  function automatic logic [25:0] ref_misr(input logic [25:0] m, input logic [25:0] d);
    logic [25:0] sh;
    sh = m << 1;
    if (m[25]) sh = sh ^ 26'h47;
    return sh ^ d;
  endfunction

  // N_PAT = 2
  logic s2 = 0, busy2, done2, sv2; logic [59:0] pi2; logic [25:0] sig2; logic [15:0] cnt2;
  c880_bist_driver #(.N_PAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .start(s2), .busy(busy2),
    .done(done2), .pi(pi2), .po(26'h1), .signature(sig2), .sig_valid(sv2), .pat_cnt(cnt2));

  // N_PAT = 64, LFSR walk
  logic s64 = 0, busy64, done64, sv64; logic [59:0] pi64; logic [25:0] sig64; logic [15:0] cnt64;
  c880_bist_driver #(.N_PAT(64)) dut64 (.clk(clk), .rst_n(rst_n), .start(s64), .busy(busy64),
    .done(done64), .pi(pi64), .po(26'h0), .signature(sig64), .sig_valid(sv64), .pat_cnt(cnt64));

  // N_PAT = 1
  logic s1 = 0, busy1, done1, sv1; logic [59:0] pi1; logic [25:0] sig1; logic [15:0] cnt1;
  c880_bist_driver #(.N_PAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(s1), .busy(busy1),
    .done(done1), .pi(pi1), .po(26'h2000000), .signature(sig1), .sig_valid(sv1), .pat_cnt(cnt1));

  // N_PAT = 8 with non-default seeds
  localparam logic [59:0] SEED8  = 60'hABC;
  localparam logic [25:0] MSEED8 = 26'h155;
  logic s8 = 0, busy8, done8, sv8; logic [59:0] pi8; logic [25:0] sig8; logic [15:0] cnt8;
  c880_bist_driver #(.N_PAT(8), .LFSR_SEED(SEED8), .MISR_SEED(MSEED8)) dut8 (.clk(clk),
    .rst_n(rst_n), .start(s8), .busy(busy8), .done(done8), .pi(pi8), .po(26'h2AA),
    .signature(sig8), .sig_valid(sv8), .pat_cnt(cnt8));

  // full run against the ALU model, plus a copy with po[0] stuck at 0
  logic sf = 0, busyf, donef, svf; logic [59:0] pif; logic [25:0] sigf, pof; logic [15:0] cntf;
  logic busys, dones, svs; logic [59:0] pis; logic [25:0] sigs, pos; logic [15:0] cnts;
  assign pof = alu(pif);
  assign pos = alu(pis) & ~26'h1;
  c880_bist_driver dutf (.clk(clk), .rst_n(rst_n), .start(sf), .busy(busyf), .done(donef),
    .pi(pif), .po(pof), .signature(sigf), .sig_valid(svf), .pat_cnt(cntf));
  c880_bist_driver duts (.clk(clk), .rst_n(rst_n), .start(sf), .busy(busys), .done(dones),
    .pi(pis), .po(pos), .signature(sigs), .sig_valid(svs), .pat_cnt(cnts));

  initial begin
    int ndone;
    logic got;
    logic [59:0] l, exp_pi;
    logic [25:0] m;

    tick(); tick();
    chk("rst_pi8", pi8, SEED8);
    chk("rst_sig8", sig8, MSEED8);
    chk("rst_pi64", pi64, 60'h1);
    chk("rst_cnt8", cnt8, 0);
    chk("rst_flags8", {busy8, done8, sv8}, 3'b000);
    rst_n = 1'b1;
    tick();
    chk("idle_hold_pi8", pi8, SEED8);

    // reset in RUN cycle 5
    s8 = 1; tick(); s8 = 0;
    chk("mr_c1_busy", busy8, 1);
    chk("mr_c1_pi", pi8, SEED8);
    tick(); tick(); tick(); tick();
    chk("mr_c5_cnt", cnt8, 4);
    rst_n = 0; tick(); rst_n = 1;
    chk("mr_busy", busy8, 0);
    chk("mr_pi", pi8, SEED8);
    chk("mr_sig", sig8, MSEED8);
    chk("mr_cnt", cnt8, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) ndone++;
      tick();
    end
    chk("mr_no_done", ndone, 0);

    // N_PAT = 2
    s2 = 1; tick(); s2 = 0;
    chk("n2_c1_done", done2, 0);
    chk("n2_c1_busy", busy2, 1);
    tick();
    chk("n2_c2_done", done2, 0);
    tick();
    chk("n2_c3_done", done2, 1);
    chk("n2_c3_busy", busy2, 0);
    chk("n2_sig", sig2, 26'h3);
    chk("n2_cnt", cnt2, 2);
    chk("n2_sv", sv2, 1);
    tick();
    chk("n2_c4_done", done2, 0);
    chk("n2_c4_sv", sv2, 1);
    chk("n2_c4_cnt", cnt2, 2);

    // LFSR walk with seed 1
    s64 = 1; tick(); s64 = 0;
    exp_pi = 60'h1;
    for (int k = 1; k <= 60; k++) begin
      chk($sformatf("lfsr_c%0d", k), pi64, exp_pi);
      exp_pi = (k < 59) ? (exp_pi << 1) : 60'h800000000000001;
      tick();
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done64) got = 1; else tick();
    end
    chk("n64_done_seen", got, 1);
    chk("n64_cnt", cnt64, 64);

    // N_PAT = 1
    s1 = 1; tick(); s1 = 0;
    chk("n1_c1_busy", busy1, 1);
    ndone = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 2) chk("n1_c2_done", done1, 1);
      if (done1) ndone++;
      tick();
    end
    chk("n1_done_once", ndone, 1);
    chk("n1_sig", sig1, 26'h2000000);
    chk("n1_cnt", cnt1, 1);

    // start held across a whole N_PAT = 8 run
    s8 = 1; tick();
    ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 9) chk("hs_c9_done", done8, 1);
      if (c == 10) begin
        chk("hs_c10_sv", sv8, 1);
        chk("hs_c10_busy", busy8, 0);
        chk("hs_c10_cnt", cnt8, 8);
      end
      if (done8) ndone++;
      tick();
    end
    chk("hs_done_once", ndone, 1);
    chk("hs_c11_busy", busy8, 1);
    chk("hs_c11_sv", sv8, 0);
    chk("hs_c11_pi", pi8, SEED8);
    s8 = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done8) got = 1; else tick();
    end
    chk("hs_rerun_done", got, 1);

    // full run
    l = 60'h1;
    m = 26'h0;
    for (int i = 0; i < 1024; i++) begin
      m = ref_misr(m, alu(l));
      l = ref_lfsr(l);
    end
    sf = 1; tick(); sf = 0;
    got = 0;
    for (int i = 0; i < 1100 && !got; i++) begin
      if (donef) got = 1; else tick();
    end
    chk("full_done_seen", got, 1);
    chk("full_sig", sigf, m);
    chk("full_cnt", cntf, 1024);
    chk("full_sv", svf, 1);
    chk("stuck_sig_differs", (sigs != m), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
